// File: rtl/wash_phase_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : wash_phase_timer_if
// Brief    : Phase indicators, controls and timer results of wash_phase_timer.
// Revision : 1.0 - initial release
// ============================================================================
interface wash_phase_timer_if;
    logic        soak_low;
    logic        soak_high;
    logic        wash_low;
    logic        wash_high;
    logic        rinse;
    logic        spin;
    logic        drain;
    logic        stop;
    logic        tick_en;
    logic        timer_soak_low;
    logic        timer_soak_high;
    logic        timer_wash_low;
    logic        timer_wash_high;
    logic        timer_rinse;
    logic        timer_spin;
    logic        timer_drain;
    logic [15:0] remaining;
    logic        busy;
    logic        phase_err;

    modport master (
        output soak_low, soak_high, wash_low, wash_high, rinse, spin, drain,
        output stop, tick_en,
        input  timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high,
        input  timer_rinse, timer_spin, timer_drain,
        input  remaining, busy, phase_err
    );

    modport slave (
        input  soak_low, soak_high, wash_low, wash_high, rinse, spin, drain,
        input  stop, tick_en,
        output timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high,
        output timer_rinse, timer_spin, timer_drain,
        output remaining, busy, phase_err
    );
endinterface
`default_nettype wire

// File: rtl/wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : wash_phase_timer
// Brief    : Times the active wash phase and emits a one-cycle done pulse.
//            Define WASH_TIMER_PRESCALE_EN to divide tick_en by PRESCALE.
// Revision : 1.0 - initial release
// ============================================================================
module wash_phase_timer #(
    parameter int SOAK_LOW_DUR  = 4,
    parameter int SOAK_HIGH_DUR = 6,
    parameter int WASH_LOW_DUR  = 5,
    parameter int WASH_HIGH_DUR = 8,
    parameter int RINSE_DUR     = 3,
    parameter int SPIN_DUR      = 3,
    parameter int DRAIN_DUR     = 2,
    parameter int PRESCALE      = 10
) (
    input  logic             clk,
    input  logic             rst,
    wash_phase_timer_if.slave bus
);

    // A duration that truncates to zero would leave a busy phase that never ends
    function automatic logic [15:0] f_load(input int dur);
        logic [15:0] v;
        v = dur[15:0];
        if (dur < 1 || v == 16'd0) begin
            f_load = 16'd1;
        end else begin
            f_load = v;
        end
    endfunction

    localparam logic [15:0] c_LOAD_SOAK_LOW  = f_load(SOAK_LOW_DUR);
    localparam logic [15:0] c_LOAD_SOAK_HIGH = f_load(SOAK_HIGH_DUR);
    localparam logic [15:0] c_LOAD_WASH_LOW  = f_load(WASH_LOW_DUR);
    localparam logic [15:0] c_LOAD_WASH_HIGH = f_load(WASH_HIGH_DUR);
    localparam logic [15:0] c_LOAD_RINSE     = f_load(RINSE_DUR);
    localparam logic [15:0] c_LOAD_SPIN      = f_load(SPIN_DUR);
    localparam logic [15:0] c_LOAD_DRAIN     = f_load(DRAIN_DUR);

    logic [6:0]  w_code;
    logic [6:0]  r_code;
    logic        w_idle;
    logic        w_multi;
    logic        w_load_ev;
    logic        w_tick;
    logic [15:0] w_load;
    logic [15:0] r_count;
    logic [15:0] w_count;
    logic        r_busy;
    logic        w_busy;
    logic        r_arm;
    logic        w_arm;
    logic        r_err;
    logic        w_err;
    logic [6:0]  r_pulse;
    logic [6:0]  w_pulse;

    assign w_code    = {bus.drain, bus.spin, bus.rinse, bus.wash_high,
                        bus.wash_low, bus.soak_high, bus.soak_low};
    assign w_idle    = (w_code == 7'd0);
    assign w_multi   = ((w_code & (w_code - 7'd1)) != 7'd0);
    assign w_load_ev = !w_idle && !w_multi && (w_code != r_code);

`ifdef WASH_TIMER_PRESCALE_EN
    localparam int                   c_PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(PRESCALE - 1);

    logic [c_PRESC_W-1:0] r_presc;
    logic                 w_wrap;

    assign w_wrap = (r_presc == c_PRESC_LAST);
    assign w_tick = bus.tick_en & w_wrap;

    // Restarting on load gives every phase a full PRESCALE period per tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
        end else if (w_load_ev || w_wrap) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + c_PRESC_W'(1);
        end
    end
`else
    logic [31:0] w_unused_prescale;

    assign w_unused_prescale = 32'(PRESCALE);
    assign w_tick            = bus.tick_en;
`endif

    always_comb begin
        case (w_code)
            7'b0000001: w_load = c_LOAD_SOAK_LOW;
            7'b0000010: w_load = c_LOAD_SOAK_HIGH;
            7'b0000100: w_load = c_LOAD_WASH_LOW;
            7'b0001000: w_load = c_LOAD_WASH_HIGH;
            7'b0010000: w_load = c_LOAD_RINSE;
            7'b0100000: w_load = c_LOAD_SPIN;
            7'b1000000: w_load = c_LOAD_DRAIN;
            default:    w_load = 16'd1;
        endcase
    end

    // Idle and error win over loading, and loading wins over the done pulse
    always_comb begin
        w_count = r_count;
        w_busy  = r_busy;
        w_arm   = r_arm;
        w_err   = 1'b0;
        w_pulse = 7'd0;
        if (w_idle) begin
            w_count = 16'd0;
            w_busy  = 1'b0;
            w_arm   = 1'b0;
        end else if (w_multi) begin
            w_err   = 1'b1;
            w_count = 16'd0;
            w_busy  = 1'b0;
            w_arm   = 1'b0;
        end else if (w_load_ev) begin
            w_count = w_load;
            w_busy  = 1'b1;
            w_arm   = 1'b1;
        end else if (w_tick && !bus.stop && (r_count != 16'd0)) begin
            w_count = r_count - 16'd1;
            if (r_count == 16'd1) begin
                w_busy = 1'b0;
                w_arm  = 1'b0;
                if (r_arm) begin
                    w_pulse = w_code;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code  <= 7'd0;
            r_count <= 16'd0;
            r_busy  <= 1'b0;
            r_arm   <= 1'b0;
            r_err   <= 1'b0;
            r_pulse <= 7'd0;
        end else begin
            r_code  <= w_code;
            r_count <= w_count;
            r_busy  <= w_busy;
            r_arm   <= w_arm;
            r_err   <= w_err;
            r_pulse <= w_pulse;
        end
    end

    assign bus.timer_soak_low  = r_pulse[0];
    assign bus.timer_soak_high = r_pulse[1];
    assign bus.timer_wash_low  = r_pulse[2];
    assign bus.timer_wash_high = r_pulse[3];
    assign bus.timer_rinse     = r_pulse[4];
    assign bus.timer_spin      = r_pulse[5];
    assign bus.timer_drain     = r_pulse[6];
    assign bus.remaining       = r_count;
    assign bus.busy            = r_busy;
    assign bus.phase_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wash_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_phase_timer
// Brief    : Directed and random stimulus against a ticks-elapsed phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wash_phase_timer;
    localparam int PRESCALE    = 10;
    localparam int DUR_TAB [7] = '{4, 6, 5, 8, 3, 3, 2};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   checking = 1'b0;

    wash_phase_timer_if bus();

    wash_phase_timer #(
        .SOAK_LOW_DUR (4), .SOAK_HIGH_DUR(6), .WASH_LOW_DUR(5), .WASH_HIGH_DUR(8),
        .RINSE_DUR    (3), .SPIN_DUR     (3), .DRAIN_DUR   (2), .PRESCALE     (PRESCALE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: which phase is loaded and how many ticks of it have elapsed
    logic [6:0] m_prev;
    logic [6:0] m_pulse;
    logic       m_loaded;
    logic       m_err;
    int         m_idx;
    int         m_elapsed;
    int         m_cyc;

    always @(posedge clk or negedge rst) begin : model
        logic [6:0] code;
        int         n;
        int         idx;
        bit         tick;
        if (!rst) begin
            m_prev    <= '0;
            m_pulse   <= '0;
            m_loaded  <= 1'b0;
            m_err     <= 1'b0;
            m_idx     <= 0;
            m_elapsed <= 0;
            m_cyc     <= 0;
        end else begin
            code = {bus.drain, bus.spin, bus.rinse, bus.wash_high,
                    bus.wash_low, bus.soak_high, bus.soak_low};
            n    = $countones(code);
            idx  = 0;
            for (int b = 0; b < 7; b++) if (code[b]) idx = b;
`ifdef WASH_TIMER_PRESCALE_EN
            tick = bus.tick_en && ((m_cyc % PRESCALE) == PRESCALE - 1);
`else
            tick = bus.tick_en;
`endif
            m_pulse <= '0;
            m_prev  <= code;
            m_err   <= (n > 1);
            m_cyc   <= m_cyc + 1;
            if (n != 1) begin
                m_loaded <= 1'b0;
            end else if (code != m_prev) begin
                m_loaded  <= 1'b1;
                m_idx     <= idx;
                m_elapsed <= 0;
                m_cyc     <= 0;
            end else if (tick && !bus.stop && m_loaded && m_elapsed < DUR_TAB[m_idx]) begin
                m_elapsed <= m_elapsed + 1;
                if (m_elapsed + 1 == DUR_TAB[m_idx]) m_pulse[m_idx] <= 1'b1;
            end
        end
    end

    logic [15:0] exp_rem;
    logic        exp_busy;
    logic [6:0]  act_pulse;

    assign exp_rem   = m_loaded ? 16'(DUR_TAB[m_idx] - m_elapsed) : 16'd0;
    assign exp_busy  = m_loaded && (m_elapsed < DUR_TAB[m_idx]);
    assign act_pulse = {bus.timer_drain, bus.timer_spin, bus.timer_rinse, bus.timer_wash_high,
                        bus.timer_wash_low, bus.timer_soak_high, bus.timer_soak_low};

    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if ({act_pulse, bus.remaining, bus.busy, bus.phase_err} !==
                {m_pulse, exp_rem, exp_busy, m_err}) begin
                miscompares++;
                $display("FAIL model t=%0t actual pulse=%b rem=%0d busy=%b err=%b required pulse=%b rem=%0d busy=%b err=%b",
                         $time, act_pulse, bus.remaining, bus.busy, bus.phase_err,
                         m_pulse, exp_rem, exp_busy, m_err);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive_code(input logic [6:0] c);
        bus.soak_low  = c[0];
        bus.soak_high = c[1];
        bus.wash_low  = c[2];
        bus.wash_high = c[3];
        bus.rinse     = c[4];
        bus.spin      = c[5];
        bus.drain     = c[6];
    endtask

    initial begin
        int          rb [10];
        int          r;
        int          a;
        int          b;
        logic [6:0]  c;
        drive_code(7'd0);
        bus.stop    = 1'b0;
        bus.tick_en = 1'b0;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        check("reset_rem", bus.remaining, 0);
        check("reset_busy", bus.busy, 0);

        // Soak high held from reset release with tick_en high
        bus.tick_en = 1'b1;
        drive_code(7'b0000010);
        rst = 1'b1;
`ifndef WASH_TIMER_PRESCALE_EN
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("soak_high_rem", bus.remaining, (k <= 6) ? 6 - k : 0);
            check("soak_high_pulse", bus.timer_soak_high, (k == 6) ? 1 : 0);
        end

        // Wash low with a 4-cycle stop after two ticks
        rb = '{5, 4, 3, 3, 3, 3, 3, 2, 1, 0};
        drive_code(7'b0000100);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stop_rem", bus.remaining, rb[k]);
            check("stop_pulse", bus.timer_wash_low, (k == 9) ? 1 : 0);
            if (k == 2) bus.stop = 1'b1;
            if (k == 6) bus.stop = 1'b0;
        end

        // Wash high abandoned at remaining 5 for drain
        drive_code(7'b0001000);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("switch_rem", bus.remaining, (k <= 3) ? 8 - k : 6 - k);
            check("switch_no_wash_high", bus.timer_wash_high, 0);
            check("switch_drain_pulse", bus.timer_drain, (k == 6) ? 1 : 0);
            if (k == 3) drive_code(7'b1000000);
        end

        // Rinse and spin together, then spin alone
        drive_code(7'b0110000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("multi_err", bus.phase_err, 1);
            check("multi_busy", bus.busy, 0);
            check("multi_rem", bus.remaining, 0);
            check("multi_pulses", act_pulse, 0);
        end
        drive_code(7'b0100000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("spin_rem", bus.remaining, 3 - k);
            check("spin_err", bus.phase_err, 0);
            check("spin_pulse", bus.timer_spin, (k == 3) ? 1 : 0);
        end
`endif

        // Asynchronous reset in the middle of soak low
        drive_code(7'b0000001);
        @(negedge clk);
        check("pre_rst_rem", bus.remaining, 4);
        #2 rst = 1'b0;
        #1;
        check("async_rst_rem", bus.remaining, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_err", bus.phase_err, 0);
        check("async_rst_pulses", act_pulse, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reload_rem", bus.remaining, 4);
        check("reload_busy", bus.busy, 1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 31));
            if (r == 0) begin
                drive_code(7'd0);
            end else if (r == 1) begin
                a = int'($urandom_range(0, 6));
                b = (a + int'($urandom_range(1, 6))) % 7;
                c = 7'd0;
                c[a] = 1'b1;
                c[b] = 1'b1;
                drive_code(c);
            end else if (r <= 3) begin
                c = 7'd0;
                c[$urandom_range(0, 6)] = 1'b1;
                drive_code(c);
            end
            bus.stop    = ($urandom_range(0, 5) == 0);
            bus.tick_en = ($urandom_range(0, 3) != 0);
        end

`ifdef WASH_TIMER_PRESCALE_EN
        @(negedge clk);
        drive_code(7'd0);
        bus.stop    = 1'b0;
        bus.tick_en = 1'b1;
        @(negedge clk);
        drive_code(7'b1000000);
        for (int k = 0; k < 23; k++) begin
            @(negedge clk);
            check("presc_drain_pulse", bus.timer_drain, (k == 20) ? 1 : 0);
        end
`endif

        @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
